hazard_stall_sequencer: RTL

- Central pipeline-control sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
- Takes load-use hazard inputs (EX load vs. ID sources), branch-taken from ID, and the data-memory ready handshake from MEM.
- Drives every pipeline-register load enable, the ID/EX bubble select (CU mux), the IF/ID flush and a WB bubble.
- Owns the multi-cycle memory-wait FSM with timeout, plus stall and flush performance counters.

---
 rtl/hazard_stall_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_sequencer
// Purpose  : 5-stage pipeline control: load-use stall, branch flush,
//            memory-wait freeze with timeout, stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_load_instr,
  input  logic [3:0]       EX_RD,
  input  logic [3:0]       ID_RN,
  input  logic [3:0]       ID_RM,
  input  logic             ID_uses_RN,
  input  logic             ID_uses_RM,
  input  logic             ID_branch_taken,
  input  logic             MEM_access,
  input  logic             MEM_ready,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             ID_EX_LE,
  output logic             EX_MEM_LE,
  output logic             MEM_WB_LE,
  output logic             CU_MUX_SIGNAL,
  output logic             IF_ID_flush,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                  c_WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_ONE     = c_WAIT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    UNUSED   = 2'b10,
    FAULT    = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [c_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    stall_q, flush_q;

  logic                w_hz;
  logic                w_mw;
  logic [c_WAIT_W-1:0] w_wait_inc;

  // Normal-flow control word (hazard/branch only, no memory wait)
  logic w_run_pc_le;
  logic w_run_if_id_le;
  logic w_run_cu_mux;
  logic w_run_flush;

  assign w_hz = EX_load_instr &
                ((ID_uses_RN & (ID_RN == EX_RD)) |
                 (ID_uses_RM & (ID_RM == EX_RD)));
  assign w_mw       = MEM_access & ~MEM_ready;
  assign w_wait_inc = wait_cnt_q + c_ONE;

  // A load-use bubble wins over a taken branch; the branch is seen again next cycle.
  always_comb begin
    w_run_pc_le    = 1'b1;
    w_run_if_id_le = 1'b1;
    w_run_cu_mux   = 1'b0;
    w_run_flush    = 1'b0;
    if (w_hz) begin
      w_run_pc_le    = 1'b0;
      w_run_if_id_le = 1'b0;
      w_run_cu_mux   = 1'b1;
    end else if (ID_branch_taken) begin
      w_run_flush    = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q;
    PC_LE         = 1'b0;
    IF_ID_LE      = 1'b0;
    ID_EX_LE      = 1'b0;
    EX_MEM_LE     = 1'b0;
    MEM_WB_LE     = 1'b0;
    CU_MUX_SIGNAL = 1'b0;
    IF_ID_flush   = 1'b0;
    MEM_WB_bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (w_mw) begin
          MEM_WB_LE     = 1'b1;
          MEM_WB_bubble = 1'b1;
          state_d       = MEM_WAIT;
          wait_cnt_d    = c_ONE;
        end else begin
          PC_LE         = w_run_pc_le;
          IF_ID_LE      = w_run_if_id_le;
          ID_EX_LE      = 1'b1;
          EX_MEM_LE     = 1'b1;
          MEM_WB_LE     = 1'b1;
          CU_MUX_SIGNAL = w_run_cu_mux;
          IF_ID_flush   = w_run_flush;
        end
      end

      MEM_WAIT: begin
        if (!MEM_ready) begin
          MEM_WB_LE     = 1'b1;
          MEM_WB_bubble = 1'b1;
          wait_cnt_d    = w_wait_inc;
          if (w_wait_inc == c_TIMEOUT) begin
            state_d = FAULT;
            err_d   = 1'b1;
          end
        end else begin
          PC_LE         = w_run_pc_le;
          IF_ID_LE      = w_run_if_id_le;
          ID_EX_LE      = 1'b1;
          EX_MEM_LE     = 1'b1;
          MEM_WB_LE     = 1'b1;
          CU_MUX_SIGNAL = w_run_cu_mux;
          IF_ID_flush   = w_run_flush;
          state_d       = RUN;
          wait_cnt_d    = '0;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (reset) begin
      PC_LE         = 1'b0;
      IF_ID_LE      = 1'b0;
      ID_EX_LE      = 1'b0;
      EX_MEM_LE     = 1'b0;
      MEM_WB_LE     = 1'b0;
      CU_MUX_SIGNAL = 1'b0;
      IF_ID_flush   = 1'b0;
      MEM_WB_bubble = 1'b0;
      state_d       = RUN;
      wait_cnt_d    = '0;
      err_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PC_LE && (state_q != FAULT) && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (IF_ID_flush && !(&flush_q)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign mem_timeout_err = err_q & ~reset;
  assign state           = state_q;
  assign stall_count     = stall_q;
  assign flush_count     = flush_q;

endmodule
`default_nettype wire
